// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: CPU byte writes are queued in a circular FIFO and drained
// onto the TxD pin as 8N1 frames at CLKS_PER_BIT clocks per bit.
// Optional feature macro: UART_TX_PARITY_EN adds an even parity bit (8E1).
module uart_tx_buffer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DEPTH_LOG2   = 4
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   input  logic                  clr_ovf,
   output logic                  cpu_ready,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  tx_busy,
   output logic                  tx_done,
   output logic                  txd
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BIT - 1);
   // With one clock per bit the stop bit is its own last cycle.
   localparam logic DONE_ON_LOAD = (CLKS_PER_BIT == 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   state_t                state;
   logic [CW-1:0]         baud_cnt;
   logic [2:0]            bit_idx;
   logic [7:0]            shreg;
   logic                  push;
   logic                  pop;
   logic                  bit_end;
`ifdef UART_TX_PARITY_EN
   logic                  parity_bit;
`endif

   // Status flags decode the registered occupancy, so a same-cycle pop cannot
   // make room for a write that arrives while full.
   assign full      = (count == (DEPTH_LOG2 + 1)'(DEPTH));
   assign empty     = (count == '0);
   assign cpu_ready = ~full;
   assign push      = wr_en && !full;
   assign bit_end   = (baud_cnt == '0);
   assign pop       = !empty && ((state == S_IDLE) || (state == S_STOP && bit_end));

   // Byte storage, written on accepted pushes.
   // NOTE: the storage array has no reset; entries are only read after count says they were written.
   always_ff @(posedge sys_clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // FIFO pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A dropped write outranks a clear in the same cycle.
         if (wr_en && full)  overflow <= 1'b1;
         else if (clr_ovf)   overflow <= 1'b0;
      end
   end

   // Serializer: walks START, DATA (LSB first), optional PARITY and STOP,
   // chaining straight into the next frame when another byte is queued.
   // NOTE: txd comes straight from a flop so the pin never sees decode glitches.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         txd        <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  state      <= S_START;
                  shreg      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                  parity_bit <= ^mem[rd_ptr];
`endif
                  baud_cnt   <= BAUD_LOAD;
                  txd        <= 1'b0;
                  tx_busy    <= 1'b1;
               end
            end
            S_START: begin
               if (bit_end) begin
                  state    <= S_DATA;
                  bit_idx  <= '0;
                  txd      <= shreg[0];
                  baud_cnt <= BAUD_LOAD;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= BAUD_LOAD;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state   <= S_PARITY;
                     txd     <= parity_bit;
`else
                     state   <= S_STOP;
                     txd     <= 1'b1;
                     tx_done <= DONE_ON_LOAD;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     txd     <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  state    <= S_STOP;
                  txd      <= 1'b1;
                  baud_cnt <= BAUD_LOAD;
                  tx_done  <= DONE_ON_LOAD;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (bit_end) begin
                  if (!empty) begin
                     state      <= S_START;
                     shreg      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                     parity_bit <= ^mem[rd_ptr];
`endif
                     baud_cnt   <= BAUD_LOAD;
                     txd        <= 1'b0;
                  end else begin
                     state      <= S_IDLE;
                     txd        <= 1'b1;
                     tx_busy    <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
                  // Pulse lands on the final stop-bit cycle.
                  tx_done  <= (baud_cnt == CW'(1));
               end
            end
            default: begin
               state   <= S_IDLE;
               txd     <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: self-checking bench for uart_tx_buffer. Expected line
// waveforms are built frame by frame from the byte values; received bytes are
// recovered by mid-bit sampling and compared against the bytes written.
`timescale 1ns/1ps
module tb_uart_tx_buffer;

   localparam int CPB   = 4;
   localparam int DL2   = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic         sys_clk = 1'b0;
   logic         sys_rst = 1'b0;
   logic         wr_en   = 1'b0;
   logic [7:0]   wr_data = 8'h00;
   logic         clr_ovf = 1'b0;
   logic         cpu_ready;
   logic         full;
   logic         empty;
   logic [DL2:0] count;
   logic         overflow;
   logic         tx_busy;
   logic         tx_done;
   logic         txd;

   int tests_run    = 0;
   int tests_failed = 0;

   // Per-cycle samples taken at the falling edge.
   logic line_q[$];
   logic done_q[$];
   logic empty_q[$];
   // Expected line and tx_done traces.
   logic exp_q[$];
   logic exp_done_q[$];
   // Bytes recovered from line_q.
   logic [7:0] rx_q[$];
   int         rx_err;

   uart_tx_buffer #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .clr_ovf   (clr_ovf),
      .cpu_ready (cpu_ready),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .txd       (txd)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   // {txd, empty, full, cpu_ready, overflow, tx_busy, tx_done, count}
   function automatic logic [11:0] status();
      return {txd, empty, full, cpu_ready, overflow, tx_busy, tx_done, count};
   endfunction

   task automatic tick();
      @(negedge sys_clk);
      line_q.push_back(txd);
      done_q.push_back(tx_done);
      empty_q.push_back(empty);
   endtask

   task automatic clear_traces();
      line_q.delete();
      done_q.delete();
      empty_q.delete();
      exp_q.delete();
      exp_done_q.delete();
   endtask

   task automatic push_idle(input int n);
      for (int c = 0; c < n; c++) begin
         exp_q.push_back(1'b1);
         exp_done_q.push_back(1'b0);
      end
   endtask

   // One frame: start, 8 data bits LSB first, [even parity], stop.
   task automatic push_frame(input logic [7:0] b);
      int ones;
      logic bits[$];
      ones = 0;
      bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) begin
         bits.push_back(b[k]);
         if (b[k]) ones++;
      end
`ifdef UART_TX_PARITY_EN
      bits.push_back((ones % 2) == 1);
`endif
      bits.push_back(1'b1);
      foreach (bits[j]) begin
         for (int c = 0; c < CPB; c++) begin
            exp_q.push_back(bits[j]);
            exp_done_q.push_back((j == NBITS - 1) && (c == CPB - 1));
         end
      end
   endtask

   // Recover bytes by sampling the middle of each bit period.
   task automatic decode(input int base);
      int i;
      int ones;
      logic [7:0] b;
      rx_q.delete();
      rx_err = 0;
      i = base;
      while (i + FRAME <= line_q.size()) begin
         if (line_q[i] === 1'b0) begin
            if (line_q[i + CPB/2] !== 1'b0) rx_err++;
            ones = 0;
            for (int k = 0; k < 8; k++) begin
               b[k] = line_q[i + (1 + k) * CPB + CPB/2];
               if (b[k]) ones++;
            end
`ifdef UART_TX_PARITY_EN
            if (line_q[i + 9 * CPB + CPB/2] !== ((ones % 2) == 1)) rx_err++;
`endif
            if (line_q[i + (NBITS - 1) * CPB + CPB/2] !== 1'b1) rx_err++;
            rx_q.push_back(b);
            i += FRAME;
         end else begin
            i++;
         end
      end
      while (i < line_q.size()) begin
         if (line_q[i] !== 1'b1) rx_err++;
         i++;
      end
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      int g;
      g = 0;
      while (!(empty && !tx_busy) && g < budget) begin
         tick();
         g++;
      end
      ok = empty && !tx_busy;
      tick();
      tick();
   endtask

   task automatic test_reset();
      sys_rst = 1'b0;
      wr_en   = 1'b0;
      clr_ovf = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      tests_run++;
      if (status() !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
         tests_failed++;
         $display("FAIL reset_hold: status=%b expected=%b", status(),
                  {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
      end
      sys_rst = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      tests_run++;
      if (status() !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
         tests_failed++;
         $display("FAIL reset_release: status=%b expected=%b", status(),
                  {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
      end
   endtask

   task automatic test_single(input logic [7:0] b);
      int bad;
      int dones;
      clear_traces();
      wr_en   = 1'b1;
      wr_data = b;
      tick();
      wr_en = 1'b0;
      tests_run++;
      if ({txd, empty, count} !== {1'b1, 1'b0, 5'd1}) begin
         tests_failed++;
         $display("FAIL single_%h_accept: txd/empty/count=%b expected=%b", b,
                  {txd, empty, count}, {1'b1, 1'b0, 5'd1});
      end
      for (int c = 0; c < FRAME + 4; c++) tick();
      push_idle(1);
      push_frame(b);
      push_idle(4);
      bad = -1;
      foreach (exp_q[i]) if (bad < 0 && line_q[i] !== exp_q[i]) bad = i;
      tests_run++;
      if (bad >= 0) begin
         tests_failed++;
         $display("FAIL single_%h_line: cycle %0d txd=%b expected=%b", b, bad,
                  line_q[bad], exp_q[bad]);
      end
      dones = 0;
      foreach (done_q[i]) if (done_q[i] === 1'b1) dones++;
      tests_run++;
      if (dones != 1 || done_q[FRAME] !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_%h_done: pulses=%0d at_frame_end=%b expected 1 pulse at cycle %0d",
                  b, dones, done_q[FRAME], FRAME);
      end
      tests_run++;
      if ({tx_busy, empty, txd} !== 3'b011) begin
         tests_failed++;
         $display("FAIL single_%h_idle: busy/empty/txd=%b expected=011", b, {tx_busy, empty, txd});
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      test_single(8'h07);
      tests_run++;
      if (line_q[9 * CPB + 1] !== 1'b1 || done_q[44] !== 1'b1) begin
         tests_failed++;
         $display("FAIL parity_07: parity=%b done@44=%b expected 1/1", line_q[9 * CPB + 1], done_q[44]);
      end
      test_single(8'h03);
      tests_run++;
      if (line_q[9 * CPB + 1] !== 1'b0 || done_q[44] !== 1'b1) begin
         tests_failed++;
         $display("FAIL parity_03: parity=%b done@44=%b expected 0/1", line_q[9 * CPB + 1], done_q[44]);
      end
   endtask
`endif

   task automatic test_back_to_back();
      logic [7:0] bytes[3];
      int bad;
      int dones;
      bytes[0] = 8'h00;
      bytes[1] = 8'hFF;
      bytes[2] = 8'h3C;
      clear_traces();
      wr_en = 1'b1;
      for (int n = 0; n < 3; n++) begin
         wr_data = bytes[n];
         tick();
      end
      wr_en = 1'b0;
      while (line_q.size() < 1 + 3 * FRAME + 6) tick();
      push_idle(1);
      for (int n = 0; n < 3; n++) push_frame(bytes[n]);
      push_idle(6);
      bad = -1;
      foreach (exp_q[i]) if (bad < 0 && (line_q[i] !== exp_q[i] || done_q[i] !== exp_done_q[i])) bad = i;
      tests_run++;
      if (bad >= 0) begin
         tests_failed++;
         $display("FAIL b2b_line: cycle %0d txd/done=%b%b expected=%b%b", bad,
                  line_q[bad], done_q[bad], exp_q[bad], exp_done_q[bad]);
      end
      dones = 0;
      foreach (done_q[i]) if (done_q[i] === 1'b1) dones++;
      tests_run++;
      if (dones != 3) begin
         tests_failed++;
         $display("FAIL b2b_done_count: got %0d expected 3", dones);
      end
      tests_run++;
      if (empty_q[2 * FRAME] !== 1'b0 || empty_q[2 * FRAME + 1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_empty: before/after last pop=%b%b expected=01",
                  empty_q[2 * FRAME], empty_q[2 * FRAME + 1]);
      end
   endtask

   task automatic test_full_overflow();
      logic [7:0] sent[$];
      int max_cnt;
      int g;
      bit ok;
      clear_traces();
      max_cnt = 0;
      for (int n = 0; n < 17; n++) begin
         wr_en   = 1'b1;
         wr_data = 8'($urandom);
         sent.push_back(wr_data);
         tick();
         if (int'(count) > max_cnt) max_cnt = int'(count);
      end
      wr_en = 1'b0;
      tests_run++;
      if ({full, cpu_ready, overflow, count} !== {1'b1, 1'b0, 1'b0, 5'd16} || max_cnt > 16) begin
         tests_failed++;
         $display("FAIL full_17: full/ready/ovf/count=%b max=%0d expected=%b max<=16",
                  {full, cpu_ready, overflow, count}, max_cnt, {1'b1, 1'b0, 1'b0, 5'd16});
      end
      wr_en   = 1'b1;
      wr_data = ~sent[16];
      tick();
      wr_en = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({overflow, count} !== {1'b1, 5'd16}) begin
         tests_failed++;
         $display("FAIL overflow_set: ovf/count=%b expected=%b", {overflow, count}, {1'b1, 5'd16});
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL overflow_clear: got %b expected 0", overflow);
      end
      wr_en   = 1'b1;
      clr_ovf = 1'b1;
      tick();
      wr_en   = 1'b0;
      clr_ovf = 1'b0;
      tests_run++;
      if ({overflow, count} !== {1'b1, 5'd16}) begin
         tests_failed++;
         $display("FAIL overflow_set_wins: ovf/count=%b expected=%b", {overflow, count}, {1'b1, 5'd16});
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      g = 0;
      while (full && g < 2 * FRAME) begin
         tick();
         g++;
      end
      tests_run++;
      if ({cpu_ready, count, txd, done_q[done_q.size() - 2]} !== {1'b1, 5'd15, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL ready_reassert: ready/count/txd/prev_done=%b expected=%b",
                  {cpu_ready, count, txd, done_q[done_q.size() - 2]}, {1'b1, 5'd15, 1'b0, 1'b1});
      end
      wait_drain(20 * FRAME, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL full_drain_timeout: empty/busy=%b%b expected=10", empty, tx_busy);
      end
      decode(0);
      tests_run++;
      if (rx_q.size() != 17 || rx_err != 0) begin
         tests_failed++;
         $display("FAIL full_frames: got %0d frames, %0d framing errors, expected 17 and 0", rx_q.size(), rx_err);
      end
      for (int n = 0; n < 17 && n < rx_q.size(); n++) begin
         tests_run++;
         if (rx_q[n] !== sent[n]) begin
            tests_failed++;
            $display("FAIL full_byte%0d: got %h expected %h", n, rx_q[n], sent[n]);
         end
      end
   endtask

   // Writes gated on cpu_ready with optional random gaps; checks byte order.
   task automatic run_stream(input string name, input int nbytes, input bit random_data, input int max_gap);
      logic [7:0] sent[$];
      int n;
      int g;
      int bad;
      bit ok;
      clear_traces();
      n = 0;
      g = 0;
      while (n < nbytes && g < 200 * FRAME) begin
         for (int k = 0, gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0; k < gap; k++) tick();
         if (cpu_ready) begin
            wr_en   = 1'b1;
            wr_data = random_data ? 8'($urandom) : 8'(n);
            sent.push_back(wr_data);
            n++;
         end
         tick();
         wr_en = 1'b0;
         g++;
      end
      wait_drain(20 * FRAME, ok);
      tests_run++;
      if (!ok || n != nbytes) begin
         tests_failed++;
         $display("FAIL %s_timeout: written %0d of %0d, empty/busy=%b%b", name, n, nbytes, empty, tx_busy);
      end
      decode(0);
      bad = -1;
      foreach (sent[i]) if (bad < 0 && (i >= rx_q.size() || rx_q[i] !== sent[i])) bad = i;
      tests_run++;
      if (bad >= 0 || rx_q.size() != sent.size() || rx_err != 0 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_data: first bad index %0d, frames %0d expected %0d, errors %0d, ovf %b",
                  name, bad, rx_q.size(), sent.size(), rx_err, overflow);
      end
   endtask

   task automatic test_wrap();
      run_stream("wrap", 40, 1'b0, 0);
   endtask

   task automatic test_random();
      run_stream("random", 12, 1'b1, 2 * FRAME);
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      int dones;
      int lows;
      b = 8'($urandom) & 8'hF7;
      clear_traces();
      wr_en   = 1'b1;
      wr_data = b;
      tick();
      wr_data = 8'($urandom);
      tick();
      wr_en = 1'b0;
      while (line_q.size() < 1 + 4 * CPB + 2) tick();
      tests_run++;
      if ({txd, tx_busy, count} !== {1'b0, 1'b1, 5'd1}) begin
         tests_failed++;
         $display("FAIL midreset_pre: txd/busy/count=%b expected=%b", {txd, tx_busy, count}, {1'b0, 1'b1, 5'd1});
      end
      sys_rst = 1'b0;
      #1;
      tests_run++;
      if (status() !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
         tests_failed++;
         $display("FAIL midreset_abort: status=%b expected=%b", status(),
                  {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
      end
      for (int c = 0; c < 3; c++) tick();
      sys_rst = 1'b1;
      clear_traces();
      for (int c = 0; c < 3 * FRAME; c++) tick();
      lows  = 0;
      dones = 0;
      foreach (line_q[i]) if (line_q[i] !== 1'b1) lows++;
      foreach (done_q[i]) if (done_q[i] !== 1'b0) dones++;
      tests_run++;
      if (lows != 0 || dones != 0 || empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_residual: low cycles %0d, done pulses %0d, empty %b expected 0/0/1",
                  lows, dones, empty);
      end
   endtask

   initial begin
      test_reset();
      test_single(8'hA5);
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_back_to_back();
      test_full_overflow();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
